transaction_arbiter: RTL and testbench
======================================

Name: transaction_arbiter

Overview:
- Shares the single transaction sequencer (the amount-verify / signature-verify / mine / finish controller) among NUM_REQ wallet requesters.
- Picks one pending request round-robin and latches its source, destination and amount.
- Pulses the sequencer's start input, then waits for completion, rejection or watchdog timeout and returns a per-requester ack/nack.
- Sits between the wallet front-ends and the transaction controller.

Parameters:
NUM_REQ, 4, number of requesters; power of two, >=2.
ID_W, 2, wallet id width; equals log2(NUM_REQ).
AMT_W, 8, transaction amount width.
TIMEOUT, 1023, maximum WAIT cycles before abort; counter width is clog2(TIMEOUT+1).

Ports:
clock  in  1  system clock; all state changes on posedge.
reset  in  1  synchronous, active-high reset.
req  in  NUM_REQ  request per requester; held high until its ack/nack.
req_dest  in  NUM_REQ*ID_W  packed destination ids; slice i belongs to requester i.
req_amount  in  NUM_REQ*AMT_W  packed amounts; slice i belongs to requester i.
txn_done  in  1  one-cycle pulse from the sequencer when Finish_Transaction completes.
txn_reject  in  1  one-cycle pulse from the sequencer when a verify step fails.
start_transaction  out  1  one-cycle start pulse to the sequencer.
txn_src  out  ID_W  latched source id (the granted index).
txn_dest  out  ID_W  latched destination id.
txn_amount  out  AMT_W  latched amount.
grant  out  NUM_REQ  one-hot; high from GRANT through WAIT.
ack  out  NUM_REQ  one-cycle success pulse to the served requester.
nack  out  NUM_REQ  one-cycle failure pulse to the served requester.
busy  out  1  high in every state except IDLE.
timeout_err  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset (reset=1 at posedge) forces IDLE from any state, including mid-transaction.
  - All outputs 0; txn_src/txn_dest/txn_amount = 0.
  - RR pointer = 0; mask = 0; watchdog = 0.
  - No ack/nack is issued for the aborted request.
- States: IDLE, GRANT, WAIT, RESPOND. Encoding is free.
- IDLE:
  - eligible = req & ~mask. Mask is cleared after one IDLE cycle.
  - If eligible != 0, choose the first set bit at or after the RR pointer, wrapping modulo NUM_REQ.
  - Latch txn_src = index, plus that index's dest and amount slices; next state GRANT.
  - If eligible == 0, stay in IDLE.
- GRANT (exactly 1 cycle): grant[idx]=1, busy=1.
  - Normal case: start_transaction=1; clear watchdog; next state WAIT.
  - Self-transfer (txn_dest == txn_src) or txn_amount == 0: start_transaction=0; set status=fail; next state RESPOND (no sequencer activity).
- WAIT: grant and latched fields held stable; watchdog increments each cycle. Checks in priority order:
  - txn_reject=1 → status=fail. Reject wins over a same-cycle txn_done.
  - txn_done=1 → status=ok.
  - watchdog == TIMEOUT → status=fail, timeout_err pulses in RESPOND. Done/reject in the same cycle as expiry take precedence over timeout.
  - Any of the above → next state RESPOND; otherwise stay in WAIT.
- RESPOND (1 cycle):
  - grant=0; ack[idx]=1 if status=ok, else nack[idx]=1.
  - RR pointer = idx+1 mod NUM_REQ.
  - mask = onehot(idx) for the next IDLE cycle only.
  - Next state IDLE.
- txn_done/txn_reject arriving in IDLE or GRANT are ignored.
- req deasserting mid-service is ignored; the service completes and ack/nack still pulses.
- Latency:
  - req high in IDLE at cycle 0 → start_transaction at cycle 1.
  - txn_done at cycle n → ack at cycle n+1 → IDLE at n+2.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 services.
- Outputs are registered or decoded from state only; no combinational path from req to start_transaction.

Test Plan:
- Reset, then req=4'b0010, dest1=3, amt1=8'd25; sequencer pulses txn_done 10 cycles after start → start_transaction at cycle 1 with txn_src=1, txn_dest=3, txn_amount=25; ack=4'b0010 one cycle after done; busy falls the following cycle.
- req=4'b1111 held; each done returned 3 cycles after start → grant order 0,1,2,3,0; no requester is served twice in succession while others wait.
- req=4'b0100 with dest2=2 (self-transfer) → no start_transaction; nack=4'b0100 two cycles after req; then the mask keeps req2 ungranted for one IDLE cycle.
- Grant requester 0, never return done; TIMEOUT=15 → after 16 WAIT cycles, nack=4'b0001 and timeout_err=1 in the same cycle; arbiter then grants the next pending requester.
- txn_done and txn_reject asserted together in WAIT → nack, not ack; separately, txn_done on the exact timeout cycle → ack with no timeout_err.
- reset asserted in WAIT while grant=4'b1000 → next cycle all outputs 0 and state IDLE; with req=4'b1000 still high, requester 3 is re-granted from RR pointer 0.

Source files
------------

// File: rtl/transaction_arbiter_if.sv
// Bundle between the wallet front-ends, the arbiter and the transaction sequencer.
// The slave modport is the arbiter; the master modport drives requests and sequencer status.
interface transaction_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int AMT_W   = 8
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*ID_W-1:0]  req_dest;
    logic [NUM_REQ*AMT_W-1:0] req_amount;
    logic                     txn_done;
    logic                     txn_reject;
    logic                     start_transaction;
    logic [ID_W-1:0]          txn_src;
    logic [ID_W-1:0]          txn_dest;
    logic [AMT_W-1:0]         txn_amount;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       ack;
    logic [NUM_REQ-1:0]       nack;
    logic                     busy;
    logic                     timeout_err;

    modport master (
        output req, req_dest, req_amount, txn_done, txn_reject,
        input  start_transaction, txn_src, txn_dest, txn_amount,
               grant, ack, nack, busy, timeout_err
    );

    modport slave (
        input  req, req_dest, req_amount, txn_done, txn_reject,
        output start_transaction, txn_src, txn_dest, txn_amount,
               grant, ack, nack, busy, timeout_err
    );
endinterface

// File: rtl/transaction_arbiter.sv
// Round-robin arbiter sharing one transaction sequencer among NUM_REQ wallet requesters.
// All outputs come straight from flops; the next-state logic decides them one cycle ahead.
module transaction_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int AMT_W   = 8,
    parameter int TIMEOUT = 1023
) (
    input logic                clock,
    input logic                reset,
    transaction_arbiter_if.slave bus
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, GRANT, WAIT, RESPOND} state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [NUM_REQ-1:0] mask_q, mask_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic [ID_W-1:0]    src_q, src_d;
    logic [ID_W-1:0]    dest_q, dest_d;
    logic [AMT_W-1:0]   amt_q, amt_d;
    logic               start_q, start_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] nack_q, nack_d;
    logic               busy_q, busy_d;
    logic               tout_q, tout_d;

    logic [NUM_REQ-1:0] eligible;
    logic               found;
    logic [ID_W-1:0]    sel, cand;
    logic [ID_W-1:0]    sel_dest;
    logic [AMT_W-1:0]   sel_amt;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
        logic [NUM_REQ-1:0] one;
        one = '0;
        one[0] = 1'b1;
        return one << idx;
    endfunction

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        mask_d   = mask_q;
        wdog_d   = wdog_q;
        src_d    = src_q;
        dest_d   = dest_q;
        amt_d    = amt_q;
        grant_d  = grant_q;
        start_d  = 1'b0;
        ack_d    = '0;
        nack_d   = '0;
        tout_d   = 1'b0;
        found    = 1'b0;
        sel      = '0;
        cand     = '0;

        // Scan from the RR pointer; ID_W-bit addition wraps modulo NUM_REQ.
        eligible = bus.req & ~mask_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = ptr_q + ID_W'(i);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        sel_dest = bus.req_dest[sel*ID_W +: ID_W];
        sel_amt  = bus.req_amount[sel*AMT_W +: AMT_W];

        unique case (state_q)
            IDLE: begin
                mask_d = '0;
                if (found) begin
                    src_d   = sel;
                    dest_d  = sel_dest;
                    amt_d   = sel_amt;
                    grant_d = onehot(sel);
                    start_d = (sel_dest != sel) && (sel_amt != '0);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if ((dest_q == src_q) || (amt_q == '0)) begin
                    nack_d  = onehot(src_q);
                    grant_d = '0;
                    state_d = RESPOND;
                end else begin
                    wdog_d  = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.txn_reject) begin
                    nack_d  = onehot(src_q);
                    grant_d = '0;
                    state_d = RESPOND;
                end else if (bus.txn_done) begin
                    ack_d   = onehot(src_q);
                    grant_d = '0;
                    state_d = RESPOND;
                end else if (wdog_q == WD_W'(TIMEOUT)) begin
                    nack_d  = onehot(src_q);
                    tout_d  = 1'b1;
                    grant_d = '0;
                    state_d = RESPOND;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            RESPOND: begin
                ptr_d   = src_q + ID_W'(1);
                mask_d  = onehot(src_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            mask_q  <= '0;
            wdog_q  <= '0;
            src_q   <= '0;
            dest_q  <= '0;
            amt_q   <= '0;
            start_q <= 1'b0;
            grant_q <= '0;
            ack_q   <= '0;
            nack_q  <= '0;
            busy_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            mask_q  <= mask_d;
            wdog_q  <= wdog_d;
            src_q   <= src_d;
            dest_q  <= dest_d;
            amt_q   <= amt_d;
            start_q <= start_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            nack_q  <= nack_d;
            busy_q  <= busy_d;
            tout_q  <= tout_d;
        end
    end

    assign bus.start_transaction = start_q;
    assign bus.txn_src           = src_q;
    assign bus.txn_dest          = dest_q;
    assign bus.txn_amount        = amt_q;
    assign bus.grant             = grant_q;
    assign bus.ack               = ack_q;
    assign bus.nack              = nack_q;
    assign bus.busy              = busy_q;
    assign bus.timeout_err       = tout_q;
endmodule

// File: tb/tb_transaction_arbiter.sv
// Scoreboarded bench for transaction_arbiter: expected responses are queued when a
// request is served and retired by a monitor whenever ack/nack fires.
module tb_transaction_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;

    transaction_arbiter_if #(.NUM_REQ(4), .ID_W(2), .AMT_W(8)) bus ();

    transaction_arbiter #(.NUM_REQ(4), .ID_W(2), .AMT_W(8), .TIMEOUT(15)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] ack;
        logic [3:0] nack;
        logic       tout;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    initial begin
        #500000;
        $display("FAIL global_timeout sim time exceeded");
        $fatal(1);
    end

    // Monitor: every response pulse must match the oldest queued expectation.
    always begin
        @(posedge clock);
        #1;
        if (reset === 1'b0 && (bus.ack | bus.nack) !== 4'b0000) begin
            total_cnt++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected ack=%b nack=%b tout=%b want no response",
                         bus.ack, bus.nack, bus.timeout_err);
            end else begin
                mon_e = sb.pop_front();
                if ({bus.ack, bus.nack, bus.timeout_err} !== {mon_e.ack, mon_e.nack, mon_e.tout})
                    $display("FAIL sb_resp ack=%b nack=%b tout=%b want ack=%b nack=%b tout=%b",
                             bus.ack, bus.nack, bus.timeout_err, mon_e.ack, mon_e.nack, mon_e.tout);
                else
                    pass_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [3:0] a, input logic [3:0] n, input logic t);
        exp_t e;
        e.ack = a; e.nack = n; e.tout = t;
        sb.push_back(e);
    endtask

    task automatic set_req(input int idx, input logic [1:0] dest, input logic [7:0] amt);
        bus.req_dest[idx*2 +: 2]   = dest;
        bus.req_amount[idx*8 +: 8] = amt;
    endtask

    task automatic wait_start(input int lim);
        int n = 0;
        while (bus.start_transaction !== 1'b1 && n < lim) begin
            tick();
            n++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req = '0;
        bus.txn_done = 1'b0;
        bus.txn_reject = 1'b0;
        tick();
        tick();
        sb.delete();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if ({bus.start_transaction, bus.grant, bus.ack, bus.nack, bus.busy, bus.timeout_err,
             bus.txn_src, bus.txn_dest, bus.txn_amount} !== 27'd0)
            $display("FAIL reset_outputs start=%b grant=%b ack=%b nack=%b busy=%b tout=%b src=%0d dest=%0d amt=%0d want all 0",
                     bus.start_transaction, bus.grant, bus.ack, bus.nack, bus.busy,
                     bus.timeout_err, bus.txn_src, bus.txn_dest, bus.txn_amount);
        else pass_cnt++;
    endtask

    task automatic test_single();
        set_req(1, 2'd3, 8'd25);
        bus.req = 4'b0010;
        tick();
        total_cnt++;
        if ({bus.start_transaction, bus.txn_src, bus.txn_dest, bus.txn_amount, bus.grant} !==
            {1'b1, 2'd1, 2'd3, 8'd25, 4'b0010})
            $display("FAIL single_start start=%b src=%0d dest=%0d amt=%0d grant=%b want 1/1/3/25/0010",
                     bus.start_transaction, bus.txn_src, bus.txn_dest, bus.txn_amount, bus.grant);
        else pass_cnt++;
        push(4'b0010, 4'b0000, 1'b0);
        repeat (10) tick();
        bus.txn_done = 1'b1;
        tick();
        bus.txn_done = 1'b0;
        total_cnt++;
        if ({bus.ack, bus.busy, bus.grant} !== {4'b0010, 1'b1, 4'b0000})
            $display("FAIL single_ack ack=%b busy=%b grant=%b want 0010/1/0000", bus.ack, bus.busy, bus.grant);
        else pass_cnt++;
        bus.req = '0;
        tick();
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL single_busy_fall busy=%b want 0", bus.busy);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [3:0] oh;
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 2'((i + 1) % 4), 8'(10 + i));
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << (k % 4);
            wait_start(12);
            total_cnt++;
            if (bus.start_transaction !== 1'b1 || bus.txn_src !== 2'(k % 4) || bus.grant !== oh)
                $display("FAIL rr_order k=%0d start=%b src=%0d grant=%b want 1/%0d/%b",
                         k, bus.start_transaction, bus.txn_src, bus.grant, k % 4, oh);
            else pass_cnt++;
            push(oh, 4'b0000, 1'b0);
            repeat (3) tick();
            bus.txn_done = 1'b1;
            tick();
            bus.txn_done = 1'b0;
            total_cnt++;
            if (bus.ack !== oh) $display("FAIL rr_ack k=%0d ack=%b want %b", k, bus.ack, oh);
            else pass_cnt++;
            if (k == 4) bus.req = '0;
        end
    endtask

    task automatic test_self_transfer();
        do_reset();
        set_req(2, 2'd2, 8'd5);
        bus.req = 4'b0100;
        tick();
        total_cnt++;
        if ({bus.start_transaction, bus.grant, bus.busy} !== {1'b0, 4'b0100, 1'b1})
            $display("FAIL self_grant start=%b grant=%b busy=%b want 0/0100/1",
                     bus.start_transaction, bus.grant, bus.busy);
        else pass_cnt++;
        push(4'b0000, 4'b0100, 1'b0);
        tick();
        total_cnt++;
        if ({bus.nack, bus.ack} !== {4'b0100, 4'b0000})
            $display("FAIL self_nack nack=%b ack=%b want 0100/0000", bus.nack, bus.ack);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({bus.grant, bus.busy} !== {4'b0000, 1'b0})
            $display("FAIL self_mask_c3 grant=%b busy=%b want 0000/0", bus.grant, bus.busy);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL self_mask_c4 busy=%b want 0", bus.busy);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.grant !== 4'b0100) $display("FAIL self_regrant grant=%b want 0100", bus.grant);
        else pass_cnt++;
        push(4'b0000, 4'b0100, 1'b0);
        tick();
        bus.req = '0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        set_req(0, 2'd1, 8'd7);
        set_req(1, 2'd0, 8'd9);
        bus.req = 4'b0011;
        tick();
        total_cnt++;
        if (bus.start_transaction !== 1'b1 || bus.txn_src !== 2'd0)
            $display("FAIL to_start start=%b src=%0d want 1/0", bus.start_transaction, bus.txn_src);
        else pass_cnt++;
        push(4'b0000, 4'b0001, 1'b1);
        repeat (16) tick();
        total_cnt++;
        if ({bus.nack, bus.timeout_err, bus.busy} !== {4'b0000, 1'b0, 1'b1})
            $display("FAIL to_early nack=%b tout=%b busy=%b want 0000/0/1", bus.nack, bus.timeout_err, bus.busy);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({bus.nack, bus.timeout_err, bus.ack} !== {4'b0001, 1'b1, 4'b0000})
            $display("FAIL to_fire nack=%b tout=%b ack=%b want 0001/1/0000", bus.nack, bus.timeout_err, bus.ack);
        else pass_cnt++;
        bus.req = 4'b0010;
        tick();
        tick();
        total_cnt++;
        if (bus.start_transaction !== 1'b1 || bus.txn_src !== 2'd1)
            $display("FAIL to_next start=%b src=%0d want 1/1", bus.start_transaction, bus.txn_src);
        else pass_cnt++;
        push(4'b0010, 4'b0000, 1'b0);
        tick();
        bus.txn_done = 1'b1;
        tick();
        bus.txn_done = 1'b0;
        total_cnt++;
        if (bus.ack !== 4'b0010) $display("FAIL to_next_ack ack=%b want 0010", bus.ack);
        else pass_cnt++;
        bus.req = '0;
        tick();
        tick();
    endtask

    task automatic test_priority();
        set_req(2, 2'd0, 8'd3);
        bus.req = 4'b0100;
        wait_start(8);
        total_cnt++;
        if (bus.start_transaction !== 1'b1 || bus.txn_src !== 2'd2)
            $display("FAIL prio_start start=%b src=%0d want 1/2", bus.start_transaction, bus.txn_src);
        else pass_cnt++;
        push(4'b0000, 4'b0100, 1'b0);
        tick();
        bus.txn_done = 1'b1;
        bus.txn_reject = 1'b1;
        tick();
        bus.txn_done = 1'b0;
        bus.txn_reject = 1'b0;
        total_cnt++;
        if ({bus.nack, bus.ack} !== {4'b0100, 4'b0000})
            $display("FAIL prio_reject_wins nack=%b ack=%b want 0100/0000", bus.nack, bus.ack);
        else pass_cnt++;
        bus.req = '0;
        tick();
        tick();

        set_req(3, 2'd1, 8'd4);
        bus.req = 4'b1000;
        wait_start(8);
        total_cnt++;
        if (bus.start_transaction !== 1'b1 || bus.txn_src !== 2'd3)
            $display("FAIL edge_start start=%b src=%0d want 1/3", bus.start_transaction, bus.txn_src);
        else pass_cnt++;
        push(4'b1000, 4'b0000, 1'b0);
        repeat (16) tick();
        bus.txn_done = 1'b1;
        tick();
        bus.txn_done = 1'b0;
        total_cnt++;
        if ({bus.ack, bus.nack, bus.timeout_err} !== {4'b1000, 4'b0000, 1'b0})
            $display("FAIL edge_done_wins ack=%b nack=%b tout=%b want 1000/0000/0",
                     bus.ack, bus.nack, bus.timeout_err);
        else pass_cnt++;
        bus.req = '0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        set_req(3, 2'd0, 8'd44);
        bus.req = 4'b1000;
        wait_start(8);
        repeat (3) tick();
        total_cnt++;
        if ({bus.grant, bus.busy} !== {4'b1000, 1'b1})
            $display("FAIL mid_wait grant=%b busy=%b want 1000/1", bus.grant, bus.busy);
        else pass_cnt++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total_cnt++;
        if ({bus.start_transaction, bus.grant, bus.ack, bus.nack, bus.busy, bus.timeout_err,
             bus.txn_src, bus.txn_dest, bus.txn_amount} !== 27'd0)
            $display("FAIL mid_reset start=%b grant=%b ack=%b nack=%b busy=%b tout=%b src=%0d dest=%0d amt=%0d want all 0",
                     bus.start_transaction, bus.grant, bus.ack, bus.nack, bus.busy,
                     bus.timeout_err, bus.txn_src, bus.txn_dest, bus.txn_amount);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({bus.start_transaction, bus.txn_src, bus.grant, bus.txn_amount} !== {1'b1, 2'd3, 4'b1000, 8'd44})
            $display("FAIL mid_regrant start=%b src=%0d grant=%b amt=%0d want 1/3/1000/44",
                     bus.start_transaction, bus.txn_src, bus.grant, bus.txn_amount);
        else pass_cnt++;
        push(4'b1000, 4'b0000, 1'b0);
        tick();
        bus.txn_done = 1'b1;
        tick();
        bus.txn_done = 1'b0;
        total_cnt++;
        if (bus.ack !== 4'b1000) $display("FAIL mid_ack ack=%b want 1000", bus.ack);
        else pass_cnt++;
        bus.req = '0;
        tick();
        tick();
    endtask

    initial begin
        bus.req = '0;
        bus.req_dest = '0;
        bus.req_amount = '0;
        bus.txn_done = 1'b0;
        bus.txn_reject = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_self_transfer();
        test_timeout();
        test_priority();
        test_reset_mid();
        total_cnt++;
        if (sb.size() != 0) $display("FAIL sb_leftover pending=%0d want 0", sb.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
